// File: rtl/rv32i_controller.sv
// ============================================================================
// Module   : rv32i_controller
// Purpose  : Main decode/control unit of the single-cycle RV32I core. Decodes
//            the instruction word and the ALU comparison flags into datapath
//            controls. Decode is purely combinational; only the sticky
//            illegal-instruction status bit (and the optional branch counter)
//            are clocked.
// Ports    : i_clk, i_rst_n           clock, asynchronous active-low reset
//            i_inst[31:0]             current instruction
//            i_zero/i_neg/i_negU      ALU compare flags (eq, signed lt, unsigned lt)
//            o_memReq/o_memWrite      data-memory request / store
//            o_memSize[1:0]           00 byte, 01 half, 10 word
//            o_regWrite               write rd
//            o_PCSrc[1:0]             00 PC+4, 01 PC+imm, 10 rs1+imm
//            o_ALUSrc                 ALU B operand: 0 rs2, 1 immediate
//            o_immSrc[2:0]            000 I, 001 S, 010 B, 011 U, 100 J
//            o_immPlusSrc             imm-adder base: 0 PC, 1 rs1
//            o_isLoadSigned           sign-extend load data
//            o_resultSrc[1:0]         00 ALU, 01 load, 10 PC+4, 11 imm-adder
//            o_ALUCtrl[3:0]           ALU operation
//            o_illegal                sticky undecodable-instruction flag
//            o_takenCount[31:0]       taken-branch counter (CTRL_BRANCH_STATS_EN)
// Options  : `define CTRL_BRANCH_STATS_EN adds the o_takenCount port/counter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rv32i_controller (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_inst,
  input  logic        i_zero,
  input  logic        i_neg,
  input  logic        i_negU,
  output logic        o_memReq,
  output logic        o_memWrite,
  output logic [1:0]  o_memSize,
  output logic        o_regWrite,
  output logic [1:0]  o_PCSrc,
  output logic        o_ALUSrc,
  output logic [2:0]  o_immSrc,
  output logic        o_immPlusSrc,
  output logic        o_isLoadSigned,
  output logic [1:0]  o_resultSrc,
  output logic [3:0]  o_ALUCtrl,
  output logic        o_illegal
`ifdef CTRL_BRANCH_STATS_EN
  ,
  output logic [31:0] o_takenCount
`endif
);

  // Major opcodes
  localparam logic [6:0] c_OP_OP     = 7'b0110011;
  localparam logic [6:0] c_OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] c_ALU_ADD   = 4'b0000;
  localparam logic [3:0] c_ALU_SUB   = 4'b1000;
  localparam logic [3:0] c_ALU_PASSB = 4'b1111;

  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_U = 3'b011;
  localparam logic [2:0] c_IMM_J = 3'b100;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_funct7b5;
  logic       w_unused;

  assign w_opcode   = i_inst[6:0];
  assign w_funct3   = i_inst[14:12];
  assign w_funct7b5 = i_inst[30];
  // Register indices and immediate bits are consumed by the datapath only.
  assign w_unused   = ^{i_inst[31], i_inst[29:15], i_inst[11:7]};

  logic       w_mem_req;
  logic       w_mem_write;
  logic [1:0] w_mem_size;
  logic       w_reg_write;
  logic [1:0] w_pc_src;
  logic       w_alu_src;
  logic [2:0] w_imm_src;
  logic       w_imm_plus_src;
  logic       w_load_signed;
  logic [1:0] w_result_src;
  logic [3:0] w_alu_ctrl;
  logic       w_illegal;
  logic       w_taken;
  logic       w_branch_taken;

  always_comb begin
    w_mem_req      = 1'b0;
    w_mem_write    = 1'b0;
    w_mem_size     = 2'b10;
    w_reg_write    = 1'b0;
    w_pc_src       = 2'b00;
    w_alu_src      = 1'b0;
    w_imm_src      = c_IMM_I;
    w_imm_plus_src = 1'b0;
    w_load_signed  = 1'b0;
    w_result_src   = 2'b00;
    w_alu_ctrl     = c_ALU_ADD;
    w_illegal      = 1'b0;
    w_taken        = 1'b0;
    w_branch_taken = 1'b0;

    case (w_opcode)
      c_OP_OP: begin
        w_reg_write = 1'b1;
        w_alu_ctrl  = {w_funct7b5, w_funct3};
      end
      c_OP_OPIMM: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        // bit 30 is immediate data except for SRAI, so ADDI never becomes SUB
        w_alu_ctrl  = {w_funct7b5 & (w_funct3 == 3'b101), w_funct3};
      end
      c_OP_LOAD: begin
        if (w_funct3 == 3'b011 || w_funct3 == 3'b110 || w_funct3 == 3'b111) begin
          w_illegal = 1'b1;
        end else begin
          w_mem_req     = 1'b1;
          w_reg_write   = 1'b1;
          w_alu_src     = 1'b1;
          w_result_src  = 2'b01;
          w_mem_size    = w_funct3[1:0];
          w_load_signed = ~w_funct3[2];
        end
      end
      c_OP_STORE: begin
        if (w_funct3 >= 3'b011) begin
          w_illegal = 1'b1;
        end else begin
          w_mem_req   = 1'b1;
          w_mem_write = 1'b1;
          w_alu_src   = 1'b1;
          w_imm_src   = c_IMM_S;
          w_mem_size  = w_funct3[1:0];
        end
      end
      c_OP_BRANCH: begin
        case (w_funct3)
          3'b000:  w_taken = i_zero;
          3'b001:  w_taken = ~i_zero;
          3'b100:  w_taken = i_neg;
          3'b101:  w_taken = ~i_neg;
          3'b110:  w_taken = i_negU;
          3'b111:  w_taken = ~i_negU;
          default: w_illegal = 1'b1;
        endcase
        if (!w_illegal) begin
          w_alu_ctrl     = c_ALU_SUB;
          w_imm_src      = c_IMM_B;
          w_branch_taken = w_taken;
          w_pc_src       = w_taken ? 2'b01 : 2'b00;
        end
      end
      c_OP_JAL: begin
        w_reg_write  = 1'b1;
        w_imm_src    = c_IMM_J;
        w_pc_src     = 2'b01;
        w_result_src = 2'b10;
      end
      c_OP_JALR: begin
        w_reg_write    = 1'b1;
        w_imm_plus_src = 1'b1;
        w_pc_src       = 2'b10;
        w_result_src   = 2'b10;
      end
      c_OP_LUI: begin
        w_reg_write = 1'b1;
        w_alu_src   = 1'b1;
        w_imm_src   = c_IMM_U;
        w_alu_ctrl  = c_ALU_PASSB;
      end
      c_OP_AUIPC: begin
        w_reg_write  = 1'b1;
        w_imm_src    = c_IMM_U;
        w_result_src = 2'b11;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // State-changing enables are held off while reset is asserted.
  assign o_memReq       = w_mem_req   & i_rst_n;
  assign o_memWrite     = w_mem_write & i_rst_n;
  assign o_regWrite     = w_reg_write & i_rst_n;
  assign o_memSize      = w_mem_size;
  assign o_PCSrc        = w_pc_src;
  assign o_ALUSrc       = w_alu_src;
  assign o_immSrc       = w_imm_src;
  assign o_immPlusSrc   = w_imm_plus_src;
  assign o_isLoadSigned = w_load_signed;
  assign o_resultSrc    = w_result_src;
  assign o_ALUCtrl      = w_alu_ctrl;

  logic r_illegal;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_illegal) begin
      r_illegal <= 1'b1;
    end
  end

  assign o_illegal = r_illegal;

`ifdef CTRL_BRANCH_STATS_EN
  logic [31:0] r_taken_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_taken_count <= 32'd0;
    end else if (w_branch_taken) begin
      r_taken_count <= r_taken_count + 32'd1;
    end
  end

  assign o_takenCount = r_taken_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv32i_controller.sv
// ============================================================================
// Module   : tb_rv32i_controller
// Purpose  : Self-checking bench for rv32i_controller. Expected control words
//            are pushed to a scoreboard queue when an instruction is driven
//            and popped/compared once the combinational outputs settle.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv32i_controller;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_inst;
  logic        i_zero;
  logic        i_neg;
  logic        i_negU;
  logic        o_memReq;
  logic        o_memWrite;
  logic [1:0]  o_memSize;
  logic        o_regWrite;
  logic [1:0]  o_PCSrc;
  logic        o_ALUSrc;
  logic [2:0]  o_immSrc;
  logic        o_immPlusSrc;
  logic        o_isLoadSigned;
  logic [1:0]  o_resultSrc;
  logic [3:0]  o_ALUCtrl;
  logic        o_illegal;
`ifdef CTRL_BRANCH_STATS_EN
  logic [31:0] o_takenCount;
`endif

  rv32i_controller dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_inst         (i_inst),
    .i_zero         (i_zero),
    .i_neg          (i_neg),
    .i_negU         (i_negU),
    .o_memReq       (o_memReq),
    .o_memWrite     (o_memWrite),
    .o_memSize      (o_memSize),
    .o_regWrite     (o_regWrite),
    .o_PCSrc        (o_PCSrc),
    .o_ALUSrc       (o_ALUSrc),
    .o_immSrc       (o_immSrc),
    .o_immPlusSrc   (o_immPlusSrc),
    .o_isLoadSigned (o_isLoadSigned),
    .o_resultSrc    (o_resultSrc),
    .o_ALUCtrl      (o_ALUCtrl),
    .o_illegal      (o_illegal)
`ifdef CTRL_BRANCH_STATS_EN
    ,
    .o_takenCount   (o_takenCount)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // {memReq, memWrite, memSize, regWrite, PCSrc, ALUSrc, immSrc,
  //  immPlusSrc, isLoadSigned, resultSrc, ALUCtrl}
  typedef struct {
    string       name;
    logic [18:0] ctrl;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic        z;
    logic        n;
    logic        nu;
    logic [18:0] ctrl;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic logic [18:0] ctl(input logic mr, input logic mw,
                                      input logic [1:0] ms, input logic rw,
                                      input logic [1:0] pc, input logic as,
                                      input logic [2:0] is, input logic ips,
                                      input logic ils, input logic [1:0] rs,
                                      input logic [3:0] alu);
    return {mr, mw, ms, rw, pc, as, is, ips, ils, rs, alu};
  endfunction

  function automatic logic [18:0] obs();
    return {o_memReq, o_memWrite, o_memSize, o_regWrite, o_PCSrc, o_ALUSrc,
            o_immSrc, o_immPlusSrc, o_isLoadSigned, o_resultSrc, o_ALUCtrl};
  endfunction

  task automatic test_reset();
    exp_t e;
    i_rst_n = 1'b0;
    i_inst  = 32'h00512223;  // sw: enables must be gated during reset
    i_zero  = 1'b0;
    i_neg   = 1'b0;
    i_negU  = 1'b0;
    sb_q.push_back('{"reset_sw_gated", ctl(0,0,2'b10,0,2'b00,1,3'b001,0,0,2'b00,4'b0000)});
    #1;
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e.ctrl) $display("FAIL %s: got %b want %b", e.name, obs(), e.ctrl);
    else n_pass++;
    i_inst = 32'h002081B3;   // add: regWrite gated
    sb_q.push_back('{"reset_add_gated", ctl(0,0,2'b10,0,2'b00,0,3'b000,0,0,2'b00,4'b0000)});
    #1;
    e = sb_q.pop_front();
    n_checks++;
    if (obs() !== e.ctrl) $display("FAIL %s: got %b want %b", e.name, obs(), e.ctrl);
    else n_pass++;
    n_checks++;
    if (o_illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", o_illegal);
    else n_pass++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_alu_ops();
    vec_t v[6];
    exp_t e;
    v[0] = '{"add",  32'h002081B3, 0,0,0, ctl(0,0,2'b10,1,2'b00,0,3'b000,0,0,2'b00,4'b0000)};
    v[1] = '{"sub",  32'h402081B3, 0,0,0, ctl(0,0,2'b10,1,2'b00,0,3'b000,0,0,2'b00,4'b1000)};
    v[2] = '{"xor",  32'h0020C1B3, 0,0,0, ctl(0,0,2'b10,1,2'b00,0,3'b000,0,0,2'b00,4'b0100)};
    v[3] = '{"sra",  32'h4020D1B3, 0,0,0, ctl(0,0,2'b10,1,2'b00,0,3'b000,0,0,2'b00,4'b1101)};
    v[4] = '{"srai", 32'h4030D093, 0,0,0, ctl(0,0,2'b10,1,2'b00,1,3'b000,0,0,2'b00,4'b1101)};
    v[5] = '{"addi_b30", 32'h40008093, 0,0,0, ctl(0,0,2'b10,1,2'b00,1,3'b000,0,0,2'b00,4'b0000)};
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      i_inst = v[i].inst; i_zero = v[i].z; i_neg = v[i].n; i_negU = v[i].nu;
      sb_q.push_back('{v[i].name, v[i].ctrl});
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) $display("FAIL %s: got %b want %b", e.name, obs(), e.ctrl);
      else n_pass++;
    end
  endtask

  task automatic test_mem();
    vec_t v[3];
    exp_t e;
    v[0] = '{"lhu", 32'h00415283, 0,0,0, ctl(1,0,2'b01,1,2'b00,1,3'b000,0,0,2'b01,4'b0000)};
    v[1] = '{"lb",  32'h00010283, 0,0,0, ctl(1,0,2'b00,1,2'b00,1,3'b000,0,1,2'b01,4'b0000)};
    v[2] = '{"sw",  32'h00512223, 0,0,0, ctl(1,1,2'b10,0,2'b00,1,3'b001,0,0,2'b00,4'b0000)};
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      i_inst = v[i].inst; i_zero = v[i].z; i_neg = v[i].n; i_negU = v[i].nu;
      sb_q.push_back('{v[i].name, v[i].ctrl});
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) $display("FAIL %s: got %b want %b", e.name, obs(), e.ctrl);
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    vec_t v[6];
    exp_t e;
    v[0] = '{"beq_taken",  32'h00208463, 1,0,0, ctl(0,0,2'b10,0,2'b01,0,3'b010,0,0,2'b00,4'b1000)};
    v[1] = '{"beq_not",    32'h00208463, 0,0,0, ctl(0,0,2'b10,0,2'b00,0,3'b010,0,0,2'b00,4'b1000)};
    v[2] = '{"bltu_taken", 32'h0020E463, 0,0,1, ctl(0,0,2'b10,0,2'b01,0,3'b010,0,0,2'b00,4'b1000)};
    v[3] = '{"bltu_not",   32'h0020E463, 1,1,0, ctl(0,0,2'b10,0,2'b00,0,3'b010,0,0,2'b00,4'b1000)};
    v[4] = '{"bge_not",    32'h0020D463, 0,1,0, ctl(0,0,2'b10,0,2'b00,0,3'b010,0,0,2'b00,4'b1000)};
    v[5] = '{"bne_taken",  32'h00209463, 0,0,0, ctl(0,0,2'b10,0,2'b01,0,3'b010,0,0,2'b00,4'b1000)};
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      i_inst = v[i].inst; i_zero = v[i].z; i_neg = v[i].n; i_negU = v[i].nu;
      sb_q.push_back('{v[i].name, v[i].ctrl});
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) $display("FAIL %s: got %b want %b", e.name, obs(), e.ctrl);
      else n_pass++;
    end
    i_zero = 1'b0; i_neg = 1'b0; i_negU = 1'b0;
  endtask

  task automatic test_jump_upper();
    vec_t v[4];
    exp_t e;
    v[0] = '{"jal",   32'h008000EF, 0,0,0, ctl(0,0,2'b10,1,2'b01,0,3'b100,0,0,2'b10,4'b0000)};
    v[1] = '{"jalr",  32'h000080E7, 0,0,0, ctl(0,0,2'b10,1,2'b10,0,3'b000,1,0,2'b10,4'b0000)};
    v[2] = '{"lui",   32'h123450B7, 0,0,0, ctl(0,0,2'b10,1,2'b00,1,3'b011,0,0,2'b00,4'b1111)};
    v[3] = '{"auipc", 32'h00001097, 0,0,0, ctl(0,0,2'b10,1,2'b00,0,3'b011,0,0,2'b11,4'b0000)};
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      i_inst = v[i].inst; i_zero = v[i].z; i_neg = v[i].n; i_negU = v[i].nu;
      sb_q.push_back('{v[i].name, v[i].ctrl});
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) $display("FAIL %s: got %b want %b", e.name, obs(), e.ctrl);
      else n_pass++;
    end
  endtask

  task automatic test_illegal_decode();
    vec_t v[4];
    exp_t e;
    logic [18:0] dflt;
    dflt = ctl(0,0,2'b10,0,2'b00,0,3'b000,0,0,2'b00,4'b0000);
    v[0] = '{"ill_opcode",   32'h0000007F, 0,0,0, dflt};
    v[1] = '{"ill_br_f3_010", 32'h0020A463, 1,1,1, dflt};
    v[2] = '{"ill_ld_f3_110", 32'h00416283, 0,0,0, dflt};
    v[3] = '{"ill_st_f3_011", 32'h00513223, 0,0,0, dflt};
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      i_inst = v[i].inst; i_zero = v[i].z; i_neg = v[i].n; i_negU = v[i].nu;
      sb_q.push_back('{v[i].name, v[i].ctrl});
      #1;
      e = sb_q.pop_front();
      n_checks++;
      if (obs() !== e.ctrl) $display("FAIL %s: got %b want %b", e.name, obs(), e.ctrl);
      else n_pass++;
    end
    i_zero = 1'b0; i_neg = 1'b0; i_negU = 1'b0;
  endtask

  task automatic test_illegal_sticky();
    // Clear any flag left by the decode test, then walk the sticky sequence.
    @(negedge i_clk);
    i_inst  = 32'h002081B3;
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_illegal !== 1'b0) $display("FAIL sticky_clear: got %b want 0", o_illegal);
    else n_pass++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_illegal !== 1'b0) $display("FAIL sticky_legal_edge: got %b want 0", o_illegal);
    else n_pass++;
    @(negedge i_clk);
    i_inst = 32'h0000007F;
    #1;
    n_checks++;
    if (o_illegal !== 1'b0 || o_regWrite !== 1'b0)
      $display("FAIL sticky_latency: got illegal=%b regWrite=%b want 0 0", o_illegal, o_regWrite);
    else n_pass++;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_illegal !== 1'b1) $display("FAIL sticky_set: got %b want 1", o_illegal);
    else n_pass++;
    @(negedge i_clk);
    i_inst = 32'h002081B3;
    @(posedge i_clk); #1;
    n_checks++;
    if (o_illegal !== 1'b1) $display("FAIL sticky_hold: got %b want 1", o_illegal);
    else n_pass++;
    #1;
    i_rst_n = 1'b0;  // mid high phase: no clock edge until the reset check
    #1;
    n_checks++;
    if (o_illegal !== 1'b0) $display("FAIL sticky_async_clear: got %b want 0", o_illegal);
    else n_pass++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

`ifdef CTRL_BRANCH_STATS_EN
  task automatic test_taken_count();
    int exp_cnt;
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_takenCount !== 32'd0) $display("FAIL cnt_reset: got %0d want 0", o_takenCount);
    else n_pass++;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      case (i)
        0, 1, 2: begin i_inst = 32'h00208463; i_zero = 1'b1; exp_cnt++; end
        3:       begin i_inst = 32'h008000EF; i_zero = 1'b0; end
        default: begin i_inst = 32'h00208463; i_zero = 1'b0; end
      endcase
      @(posedge i_clk);
    end
    #1;
    n_checks++;
    if (o_takenCount !== exp_cnt) $display("FAIL cnt_taken: got %0d want %0d", o_takenCount, exp_cnt);
    else n_pass++;
    i_zero = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_alu_ops();
    test_mem();
    test_branch();
    test_jump_upper();
    test_illegal_decode();
    test_illegal_sticky();
`ifdef CTRL_BRANCH_STATS_EN
    test_taken_count();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard stop so a stalled run still terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/rv32i_controller.md
Name: rv32i_controller

Overview:
- Main decode/control unit of the single-cycle RV32I core.
- Decodes the 32-bit instruction and the ALU comparison flags.
- Drives memory-request, register-write, PC-select, immediate, result-mux and ALU-operation controls.
- Decode is combinational. One sticky illegal-instruction status register is clocked.

Parameters:
- none

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  asynchronous active-low reset
- i_inst  input  32  current instruction
- i_zero  input  1  ALU result == 0 (rs1 == rs2 after SUB)
- i_neg  input  1  signed rs1 < rs2
- i_negU  input  1  unsigned rs1 < rs2
- o_memReq  output  1  data-memory access this cycle
- o_memWrite  output  1  store (valid with o_memReq)
- o_memSize  output  2  00 byte, 01 half, 10 word
- o_regWrite  output  1  write rd
- o_PCSrc  output  2  00 PC+4, 01 PC+imm, 10 rs1+imm
- o_ALUSrc  output  1  ALU B operand: 0 rs2, 1 immediate
- o_immSrc  output  3  000 I, 001 S, 010 B, 011 U, 100 J
- o_immPlusSrc  output  1  imm-adder base: 0 PC, 1 rs1
- o_isLoadSigned  output  1  sign-extend load data
- o_resultSrc  output  2  rd source: 00 ALU, 01 load data, 10 PC+4, 11 imm-adder
- o_ALUCtrl  output  4  ALU operation
- o_illegal  output  1  sticky: an undecodable instruction was seen

Behaviour:
- Fields: opcode = inst[6:0], funct3 = inst[14:12], funct7b5 = inst[30].
- ALUCtrl encoding: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1111 PASS-B.
- OP (0110011): regWrite, ALUSrc 0, resultSrc 00, ALUCtrl = {funct7b5, funct3}.
- OP-IMM (0010011): regWrite, ALUSrc 1, immSrc I, ALUCtrl = {funct7b5 & (funct3==101), funct3}. ADDI never yields SUB.
- LOAD (0000011): memReq, regWrite, ALUSrc 1, immSrc I, ADD, resultSrc 01, memSize = funct3[1:0], isLoadSigned = ~funct3[2].
- STORE (0100011): memReq, memWrite, ALUSrc 1, immSrc S, ADD, memSize = funct3[1:0].
- BRANCH (1100011): ALUSrc 0, SUB, immSrc B, immPlusSrc 0.
  - Taken test by funct3: 000 zero, 001 ~zero, 100 neg, 101 ~neg, 110 negU, 111 ~negU.
  - PCSrc = taken ? 01 : 00.
- JAL (1101111): regWrite, immSrc J, immPlusSrc 0, PCSrc 01, resultSrc 10.
- JALR (1100111): regWrite, immSrc I, immPlusSrc 1, PCSrc 10, resultSrc 10. The datapath clears target bit 0.
- LUI (0110111): regWrite, ALUSrc 1, immSrc U, PASS-B, resultSrc 00.
- AUIPC (0010111): regWrite, immSrc U, immPlusSrc 0, resultSrc 11.
- Default values for every output: all enables 0, PCSrc 00, ALUCtrl 0000, memSize 10, other fields 0.
- Illegal instruction: unknown opcode, or funct3 010/011 on BRANCH, or load funct3 011/110/111, or store funct3 >= 011.
  - Outputs take their default values. The PC advances by 4.
  - o_illegal is set on the next rising i_clk and holds until reset.
- Reset: while i_rst_n = 0, o_memReq, o_memWrite and o_regWrite are forced to 0 (combinational gate). o_illegal clears to 0 immediately (asynchronous).
- Latency: control outputs are zero-latency combinational. o_illegal has one-cycle latency.

Optional Feature:
- Macro: CTRL_BRANCH_STATS_EN
- Defined: adds output o_takenCount [31:0]. It increments on each rising i_clk where a BRANCH is taken (PCSrc 01 from BRANCH, excluding JAL). It wraps at 2^32 and clears asynchronously on reset.
- Undefined: the port and counter are absent.

Test Plan:
- add x3,x1,x2 (0x002081B3) -> regWrite 1, ALUSrc 0, ALUCtrl 0000, resultSrc 00, memReq 0.
- sub (0x402081B3) -> ALUCtrl 1000; srai x1,x1,3 (0x4030D093) -> ALUCtrl 1101, ALUSrc 1, immSrc 000.
- lhu x5,4(x2) (0x00415283) -> memReq 1, memWrite 0, memSize 01, isLoadSigned 0, resultSrc 01.
- sw (0x00512223) -> memReq 1, memWrite 1, memSize 10, immSrc 001, regWrite 0.
- beq (0x00208463):
  - i_zero 1 -> PCSrc 01.
  - i_zero 0 -> PCSrc 00.
- bltu with i_negU 1 -> PCSrc 01.
- jalr (0x000080E7) -> PCSrc 10, immPlusSrc 1, resultSrc 10.
- Opcode 0x7F on a clock edge -> o_illegal 1 next cycle, regWrite 0. Pulse i_rst_n low -> o_illegal 0 immediately.
